// File: rtl/alu_exec.sv
// Execute stage: single-cycle add/sub/compare plus an iterative restoring divider.
// Valid/ready on both sides; one command in flight at a time.
module alu_exec #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned OP_WIDTH   = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  op_valid,
  output logic                  op_ready,
  input  logic [OP_WIDTH-1:0]   opcode,
  input  logic [DATA_WIDTH-1:0] opa,
  input  logic [DATA_WIDTH-1:0] opb,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  flag,
  output logic                  div_zero,
  output logic                  illegal
);

  localparam int unsigned CntW = $clog2(DATA_WIDTH + 1);

  localparam logic [OP_WIDTH-1:0] OpAdd   = OP_WIDTH'(8'h20);
  localparam logic [OP_WIDTH-1:0] OpSub   = OP_WIDTH'(8'h21);
  localparam logic [OP_WIDTH-1:0] OpMod   = OP_WIDTH'(8'h22);
  localparam logic [OP_WIDTH-1:0] OpDiv   = OP_WIDTH'(8'h23);
  localparam logic [OP_WIDTH-1:0] OpLarge = OP_WIDTH'(8'h28);
  localparam logic [OP_WIDTH-1:0] OpSmall = OP_WIDTH'(8'h29);
  localparam logic [OP_WIDTH-1:0] OpEqual = OP_WIDTH'(8'h2A);

  typedef enum logic [1:0] {StIdle, StDiv, StDone} state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] rem_q, rem_d;
  logic [DATA_WIDTH-1:0] quo_q, quo_d;
  logic [DATA_WIDTH-1:0] dvs_q, dvs_d;
  logic [DATA_WIDTH-1:0] result_q, result_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic                  is_mod_q, is_mod_d;
  logic                  flag_q, flag_d;
  logic                  dz_q, dz_d;
  logic                  ill_q, ill_d;

  logic [DATA_WIDTH:0]   sum, diff, rem_sh;
  logic [DATA_WIDTH-1:0] rem_sub, rem_step, quo_step;
  logic                  step_ge;

  assign op_ready  = (state_q == StIdle);
  assign res_valid = (state_q == StDone);
  assign result    = result_q;
  assign flag      = flag_q;
  assign div_zero  = dz_q;
  assign illegal   = ill_q;

  assign sum  = {1'b0, opa} + {1'b0, opb};
  assign diff = {1'b0, opa} - {1'b0, opb};

  // One restoring step on the {rem, dividend} pair; rem_sh needs W+1 bits before the compare.
  assign rem_sh   = {rem_q, quo_q[DATA_WIDTH-1]};
  assign step_ge  = (rem_sh >= {1'b0, dvs_q});
  assign rem_sub  = rem_sh[DATA_WIDTH-1:0] - dvs_q;
  assign rem_step = step_ge ? rem_sub : rem_sh[DATA_WIDTH-1:0];
  assign quo_step = {quo_q[DATA_WIDTH-2:0], step_ge};

  always_comb begin
    state_d  = state_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvs_d    = dvs_q;
    cnt_d    = cnt_q;
    is_mod_d = is_mod_q;
    result_d = result_q;
    flag_d   = flag_q;
    dz_d     = dz_q;
    ill_d    = ill_q;
    unique case (state_q)
      StIdle: begin
        if (op_valid) begin
          state_d  = StDone;
          result_d = '0;
          flag_d   = 1'b0;
          dz_d     = 1'b0;
          ill_d    = 1'b0;
          case (opcode)
            OpAdd: begin
              result_d = sum[DATA_WIDTH-1:0];
              flag_d   = sum[DATA_WIDTH];
            end
            OpSub: begin
              result_d = diff[DATA_WIDTH-1:0];
              flag_d   = diff[DATA_WIDTH];
            end
            OpLarge: begin
              flag_d   = (opa > opb);
              result_d = DATA_WIDTH'(opa > opb);
            end
            OpSmall: begin
              flag_d   = (opa < opb);
              result_d = DATA_WIDTH'(opa < opb);
            end
            OpEqual: begin
              flag_d   = (opa == opb);
              result_d = DATA_WIDTH'(opa == opb);
            end
            OpDiv, OpMod: begin
              if (opb == '0) begin
                dz_d     = 1'b1;
                result_d = (opcode == OpDiv) ? '1 : opa;
              end else begin
                state_d  = StDiv;
                rem_d    = '0;
                quo_d    = opa;
                dvs_d    = opb;
                cnt_d    = '0;
                is_mod_d = (opcode == OpMod);
              end
            end
            default: ill_d = 1'b1;
          endcase
        end
      end
      StDiv: begin
        rem_d = rem_step;
        quo_d = quo_step;
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == CntW'(DATA_WIDTH - 1)) begin
          state_d  = StDone;
          result_d = is_mod_q ? rem_step : quo_step;
          flag_d   = 1'b0;
        end
      end
      StDone: begin
        if (res_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      cnt_q    <= '0;
      is_mod_q <= 1'b0;
      result_q <= '0;
      flag_q   <= 1'b0;
      dz_q     <= 1'b0;
      ill_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvs_q    <= dvs_d;
      cnt_q    <= cnt_d;
      is_mod_q <= is_mod_d;
      result_q <= result_d;
      flag_q   <= flag_d;
      dz_q     <= dz_d;
      ill_q    <= ill_d;
    end
  end

endmodule

// File: tb/tb_alu_exec.sv
// Scoreboard bench for alu_exec: driver pushes model expectations, monitor pops on res_valid.
module tb_alu_exec;

  localparam logic [7:0] ADD = 8'h20, SUB = 8'h21, MOD = 8'h22, DIV = 8'h23;
  localparam logic [7:0] LARGE = 8'h28, SMALL = 8'h29, EQUAL = 8'h2A;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       op_valid = 1'b0;
  logic       op_ready;
  logic [7:0] opcode = '0;
  logic [7:0] opa = '0;
  logic [7:0] opb = '0;
  logic       res_valid;
  logic       res_ready = 1'b1;
  logic [7:0] result;
  logic       flag;
  logic       div_zero;
  logic       illegal;

  alu_exec #(.DATA_WIDTH(8), .OP_WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .op_valid  (op_valid),
    .op_ready  (op_ready),
    .opcode    (opcode),
    .opa       (opa),
    .opb       (opb),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .result    (result),
    .flag      (flag),
    .div_zero  (div_zero),
    .illegal   (illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] res;
    logic       flag;
    logic       dz;
    logic       ill;
    int         lat;
    int         acc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  bit   bp_en = 1'b0;

  always @(posedge clk) cyc++;

  always @(negedge clk) if (bp_en) res_ready = ($urandom_range(0, 3) != 0);

  task automatic chk(input string nm, input int act, input int expv);
    checks++;
    if (act != expv) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, expv, $time);
    end
  endtask

  function automatic exp_t model(input logic [7:0] op, input logic [7:0] a, input logic [7:0] b);
    exp_t e;
    int   ia, ib;
    ia = int'(a);
    ib = int'(b);
    e.res = '0; e.flag = 1'b0; e.dz = 1'b0; e.ill = 1'b0; e.lat = 1; e.acc = 0;
    case (op)
      ADD: begin e.res = 8'((ia + ib) % 256); e.flag = (ia + ib) > 255; end
      SUB: begin e.res = 8'((256 + ia - ib) % 256); e.flag = ia < ib; end
      DIV: if (ib == 0) begin e.res = 8'hFF; e.dz = 1'b1; end
           else begin e.res = 8'(ia / ib); e.lat = 9; end
      MOD: if (ib == 0) begin e.res = a; e.dz = 1'b1; end
           else begin e.res = 8'(ia % ib); e.lat = 9; end
      LARGE: begin e.flag = ia > ib; e.res = {7'b0, e.flag}; end
      SMALL: begin e.flag = ia < ib; e.res = {7'b0, e.flag}; end
      EQUAL: begin e.flag = ia == ib; e.res = {7'b0, e.flag}; end
      default: e.ill = 1'b1;
    endcase
    return e;
  endfunction

  // Monitor: pops once per result, then checks it is held stable while res_valid stays high.
  bit   seen = 1'b0;
  bit   have_cur = 1'b0;
  exp_t cur;
  always @(negedge clk) begin
    if (!rst_n) begin
      seen = 1'b0;
    end else if (res_valid) begin
      if (!seen) begin
        seen = 1'b1;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          have_cur = 1'b0;
          $display("FAIL unexpected_result: got result %0h with empty scoreboard", result);
        end else begin
          cur = exp_q.pop_front();
          have_cur = 1'b1;
          chk("latency", cyc - cur.acc, cur.lat);
        end
      end
      if (have_cur) begin
        chk("result", int'(result), int'(cur.res));
        chk("flag", int'(flag), int'(cur.flag));
        chk("div_zero", int'(div_zero), int'(cur.dz));
        chk("illegal", int'(illegal), int'(cur.ill));
      end
      chk("op_ready_busy", int'(op_ready), 0);
    end else begin
      seen = 1'b0;
    end
  end

  task automatic issue(input logic [7:0] op, input logic [7:0] a, input logic [7:0] b,
                       input bit push);
    exp_t e;
    int   n;
    @(negedge clk);
    op_valid = 1'b1; opcode = op; opa = a; opb = b;
    n = 0;
    while (!op_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!op_ready) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout: op_ready %0b expected 1", op_ready);
    end else if (push) begin
      e = model(op, a, b);
      e.acc = cyc;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    op_valid = 1'b0;
    opcode = 8'($urandom); opa = 8'($urandom); opb = 8'($urandom);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || !op_ready) && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending", exp_q.size(), 0);
  endtask

  logic [7:0] ops [8];
  logic [7:0] rop, ra, rb;

  initial begin
    ops[0] = ADD; ops[1] = SUB; ops[2] = MOD; ops[3] = DIV;
    ops[4] = LARGE; ops[5] = SMALL; ops[6] = EQUAL; ops[7] = 8'h55;

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_op_ready", int'(op_ready), 1);
    chk("rst_res_valid", int'(res_valid), 0);
    chk("rst_result", int'(result), 0);
    chk("rst_flag", int'(flag), 0);
    chk("rst_div_zero", int'(div_zero), 0);
    chk("rst_illegal", int'(illegal), 0);
    rst_n = 1'b1;

    issue(ADD, 8'hF0, 8'h20, 1);
    issue(DIV, 8'd200, 8'd7, 1);
    issue(MOD, 8'd200, 8'd7, 1);
    issue(DIV, 8'h55, 8'h00, 1);
    issue(MOD, 8'h55, 8'h00, 1);
    issue(ADD, 8'd1, 8'd1, 1);
    issue(SUB, 8'd3, 8'd5, 1);
    issue(LARGE, 8'd9, 8'd3, 1);
    issue(SMALL, 8'd9, 8'd3, 1);
    issue(EQUAL, 8'd7, 8'd7, 1);
    issue(8'h55, 8'd1, 8'd2, 1);
    issue(DIV, 8'd0, 8'd5, 1);
    issue(DIV, 8'd77, 8'd1, 1);
    issue(MOD, 8'd77, 8'd1, 1);
    issue(DIV, 8'd3, 8'd200, 1);
    issue(MOD, 8'd3, 8'd200, 1);
    drain();

    // Backpressure: hold the result, wiggle op_valid, then release.
    res_ready = 1'b0;
    issue(DIV, 8'd100, 8'd9, 1);
    begin
      int n;
      n = 0;
      while (!res_valid && n < 50) begin
        @(negedge clk);
        n++;
      end
      chk("bp_res_valid", int'(res_valid), 1);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      op_valid = i[0]; opcode = ADD; opa = 8'd1; opb = 8'd1;
    end
    @(negedge clk);
    op_valid = 1'b0;
    res_ready = 1'b1;
    issue(ADD, 8'd2, 8'd3, 1);
    drain();

    // Reset during iteration 4 of a divide aborts it without a result.
    issue(DIV, 8'd255, 8'd2, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_res_valid", int'(res_valid), 0);
    chk("abort_op_ready", int'(op_ready), 1);
    chk("abort_result", int'(result), 0);
    rst_n = 1'b1;
    issue(DIV, 8'd255, 8'd2, 1);
    drain();

    bp_en = 1'b1;
    for (int i = 0; i < 200; i++) begin
      rop = ops[$urandom_range(0, 7)];
      ra = 8'($urandom);
      case ($urandom_range(0, 7))
        0: rb = 8'd0;
        1: rb = 8'd1;
        2: rb = 8'($urandom_range(0, 15));
        default: rb = 8'($urandom);
      endcase
      issue(rop, ra, rb, 1);
    end
    @(negedge clk);
    bp_en = 1'b0;
    res_ready = 1'b1;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/alu_exec.md
Name: alu_exec

Overview:
- Execute stage directly downstream of ir_decoder. Accepts one arithmetic/compare command (opcode plus two operands) per handshake and returns a registered result and flag.
- Single-cycle ops: ADD, SUB, LARGE, SMALL, EQUAL.
- DIV/MOD use an iterative restoring divider, one quotient bit per cycle.
- valid/ready on both sides, so the decoder stalls while a divide is in flight.

Parameters:
DATA_WIDTH, 8, operand/result width (W); must be >= 2
OP_WIDTH, 8, opcode width

Ports:
clk  input  1  clock
rst_n  input  1  reset, synchronous, active-low
op_valid  input  1  command present
op_ready  output  1  block can accept command
opcode  input  OP_WIDTH  ADD=0x20 SUB=0x21 MOD=0x22 DIV=0x23 LARGE=0x28 SMALL=0x29 EQUAL=0x2A
opa  input  DATA_WIDTH  operand A (unsigned)
opb  input  DATA_WIDTH  operand B (unsigned)
res_valid  output  1  result present
res_ready  input  1  consumer takes result
result  output  DATA_WIDTH  result value
flag  output  1  carry / borrow / compare outcome
div_zero  output  1  DIV/MOD with opb==0
illegal  output  1  opcode not in list

Behaviour:
- Reset:
  - Sync, active-low; overrides everything, including an in-flight divide (aborted, no result).
  - Reset values: state=IDLE, op_ready=1, res_valid=0, result=0, flag=0, div_zero=0, illegal=0, iteration counter=0.
- FSM states IDLE, DIV, DONE:
  - op_ready = (state==IDLE). Combinational from state only; never depends on op_valid.
  - Accept = op_valid & op_ready at a rising edge; opcode/opa/opb are captured on that edge.
- IDLE, on accept:
  - DIV/MOD with opb!=0 -> DIV; load remainder=0, dividend=opa, divisor=opb, counter=0, latch op type.
  - All other opcodes -> DONE with outputs written on the same edge, so latency is 1 (res_valid high the cycle after accept).
- DIV state:
  - Each edge performs one restoring step:
    - shift {rem,dividend} left by 1;
    - if rem>=divisor, subtract and set quotient LSB to 1;
    - counter increments.
  - After W iteration edges: ->DONE, result = quotient (DIV) or remainder (MOD), flag=0. Total latency W+1 edges from accept.
  - op_valid is ignored; inputs are not re-sampled.
- DONE state:
  - res_valid=1; result/flag/div_zero/illegal are held stable.
  - res_ready=1 at an edge -> IDLE, res_valid=0 next cycle. Outputs keep their last values but are don't-care when res_valid=0.
  - Minimum spacing between accepts is 2 cycles (1-cycle op).
- Arithmetic (all unsigned, results mod 2^W):
  - ADD: result=opa+opb, flag=carry out.
  - SUB: result=opa-opb, flag=borrow (opa<opb).
  - LARGE: flag=(opa>opb). SMALL: flag=(opa<opb). EQUAL: flag=(opa==opb). For all three, result={W-1 zeros,flag}.
  - DIV/MOD with opb==0: no iteration, latency 1, div_zero=1, flag=0; DIV result=all ones, MOD result=opa.
  - Other opcodes: latency 1, illegal=1, result=0, flag=0.
  - div_zero and illegal are cleared for every normal command.
- Boundaries:
  - opa=0 divide still takes the full W iterations.
  - opb=1 yields quotient opa, remainder 0.
  - opa<opb yields quotient 0, remainder opa.
  - A res_ready pulse outside DONE has no effect.
  - A command arriving while busy is held by the producer; nothing is dropped or overwritten.

Test Plan (W=8):
- ADD opa=0xF0 opb=0x20 -> one cycle after accept: res_valid=1, result=0x10, flag=1; op_ready low until result consumed.
- DIV opa=200 opb=7 -> res_valid exactly 9 cycles after accept, result=28, flag=0; MOD same operands -> result=4.
- DIV opa=0x55 opb=0 -> latency 1, result=0xFF, div_zero=1; MOD -> result=0x55, div_zero=1; next ADD 1+1 -> result=2, div_zero=0.
- SUB 3-5 -> result=0xFE, flag=1; LARGE 9,3 -> result=1; SMALL 9,3 -> 0; EQUAL 7,7 -> flag=1; opcode 0x55 -> illegal=1, result=0.
- Backpressure: DIV 100/9, hold res_ready=0 for 5 cycles after res_valid -> result stays 11, op_ready stays 0; op_valid pulses are ignored. Release -> IDLE, then next command accepted.
- Reset mid-divide: assert rst_n=0 for one edge at iteration 4 of DIV 255/2 -> res_valid=0, op_ready=1, result=0. A fresh DIV 255/2 -> 127 after 9 cycles.
